// File: rtl/crash_course_cpu_io_bridge.sv
// CPU IO window bridge: CPU stores to the IO window are queued in a small TX FIFO
// for an external byte stream, and an inbound byte stream fills the IO byte registers.
module crash_course_cpu_io_bridge #(
  parameter int TX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             clk_en,
  input  logic             system_enabled,
  input  logic [15:0][7:0] io_out,
  input  logic             io_write_en,
  input  logic [3:0]       io_write_index,
  input  logic             io_read_en,
  input  logic [3:0]       io_read_index,
  output logic [15:0][7:0] io_in,
  output logic [15:0]      rx_pending,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic [3:0]       tx_index,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic [3:0]       rx_index,
  output logic             tx_overflow,
  input  logic             tx_overflow_clr
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = $clog2(TX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);

  logic [11:0]      mem_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0][7:0] io_in_q, io_in_d;
  logic [15:0]      pend_q, pend_d;

  logic step, push_req, full, pop, push, ovf_set;
  logic rx_read_hit, rx_hs;

  assign step     = clk_en && system_enabled;
  assign push_req = step && io_write_en;
  assign full     = (cnt_q == DEPTH_C);

  // TX side: head is presented whenever the FIFO holds data, regardless of tx_ready.
  always_comb begin
    tx_valid = (cnt_q != '0) && !sync_rst;
    tx_index = '0;
    tx_data  = '0;
    if (tx_valid) begin
      {tx_index, tx_data} = mem_q[rd_ptr_q];
    end
  end

  assign pop     = step && tx_valid && tx_ready;
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // A fresh overflow outranks a clear request in the same cycle.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (step && tx_overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // RX side: a pending byte blocks a new receive unless the CPU loads it this cycle.
  assign rx_read_hit = io_read_en && (io_read_index == rx_index);
  assign rx_ready    = step && !sync_rst && !(pend_q[rx_index] && !rx_read_hit);
  assign rx_hs       = rx_valid && rx_ready;

  always_comb begin
    io_in_d = io_in_q;
    pend_d  = pend_q;
    if (step && io_read_en) begin
      pend_d[io_read_index] = 1'b0;
    end
    if (rx_hs) begin
      io_in_d[rx_index] = rx_data;
      pend_d[rx_index]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      io_in_q  <= '0;
      pend_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      io_in_q  <= io_in_d;
      pend_q   <= pend_d;
    end
  end

  // FIFO storage is data only; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {io_write_index, io_out[io_write_index]};
    end
  end

  assign io_in       = io_in_q;
  assign rx_pending  = pend_q;
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_crash_course_cpu_io_bridge.sv
// Randomized and directed bench for crash_course_cpu_io_bridge against a queue-based model.
module tb_crash_course_cpu_io_bridge;
  localparam int TX_DEPTH = 4;

  logic             clk = 1'b0;
  logic             sync_rst, clk_en, system_enabled;
  logic [15:0][7:0] io_out;
  logic             io_write_en, io_read_en;
  logic [3:0]       io_write_index, io_read_index;
  logic [15:0][7:0] io_in;
  logic [15:0]      rx_pending;
  logic             tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]       tx_data, rx_data;
  logic [3:0]       tx_index, rx_index;
  logic             tx_overflow, tx_overflow_clr;

  int checks = 0;
  int errors = 0;

  logic [11:0]      mq[$];
  logic [15:0][7:0] m_io;
  logic [15:0]      m_pend;
  logic             m_ovf;

  always #5 clk = ~clk;

  crash_course_cpu_io_bridge #(.TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .system_enabled(system_enabled),
    .io_out(io_out), .io_write_en(io_write_en), .io_write_index(io_write_index),
    .io_read_en(io_read_en), .io_read_index(io_read_index), .io_in(io_in),
    .rx_pending(rx_pending), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_index(tx_index), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_index(rx_index), .tx_overflow(tx_overflow), .tx_overflow_clr(tx_overflow_clr)
  );

  function automatic logic m_rx_ready();
    return clk_en && system_enabled && !sync_rst &&
           !(m_pend[rx_index] && !(io_read_en && io_read_index == rx_index));
  endfunction

  // Advance the reference model by one clock, then move to the next falling edge.
  task automatic tick();
    logic st, pop, rdy;
    int   n;
    st  = clk_en && system_enabled;
    rdy = m_rx_ready();
    n   = mq.size();
    if (sync_rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_pend = '0;
      m_io   = '0;
    end else if (st) begin
      pop = (n > 0) && tx_ready;
      if (io_write_en && n == TX_DEPTH && !pop) m_ovf = 1'b1;
      else if (tx_overflow_clr) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (io_write_en && (n < TX_DEPTH || pop)) mq.push_back({io_write_index, io_out[io_write_index]});
      if (io_read_en) m_pend[io_read_index] = 1'b0;
      if (rx_valid && rdy) begin
        m_io[rx_index]   = rx_data;
        m_pend[rx_index] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    sync_rst = 0; clk_en = 1; system_enabled = 1; io_out = '0;
    io_write_en = 0; io_write_index = 0; io_read_en = 0; io_read_index = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; rx_index = 0; tx_overflow_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    sync_rst = 1;
    tick();
    sync_rst = 0;
  endtask

  task automatic push_byte(input logic [3:0] idx, input logic [7:0] d);
    io_write_en = 1; io_write_index = idx; io_out[idx] = d;
    tick();
    io_write_en = 0;
  endtask

  task automatic test_reset();
    idle();
    sync_rst = 1; clk_en = 0; rx_valid = 1; rx_index = 4'd6; rx_data = 8'hEE;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %0b exp 0", tx_valid); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got %0b exp 0", rx_ready); end
    tick();
    idle();
    #1;
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", tx_overflow); end
    checks++; if (rx_pending !== 16'h0000) begin errors++; $display("FAIL rst_pend got %h exp 0000", rx_pending); end
    checks++; if (io_in !== '0) begin errors++; $display("FAIL rst_io_in got %h exp 0", io_in); end
    checks++; if ({tx_valid, tx_index, tx_data} !== 13'h0) begin errors++; $display("FAIL rst_tx_out got %h exp 0", {tx_valid, tx_index, tx_data}); end
  endtask

  task automatic test_single_write();
    do_reset();
    io_out = {$urandom, $urandom, $urandom, $urandom};
    io_out[3] = 8'hA5; io_write_en = 1; io_write_index = 4'd3; tx_ready = 1;
    tick();
    io_write_en = 0;
    #1;
    checks++; if ({tx_valid, tx_index, tx_data} !== {1'b1, 4'd3, 8'hA5})
      begin errors++; $display("FAIL single_head got %b/%h/%h exp 1/3/a5", tx_valid, tx_index, tx_data); end
    tick();
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b exp 0", tx_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) push_byte(4'(i), 8'(i));
    #1;
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", tx_overflow); end
    tx_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(k))
        begin errors++; $display("FAIL ovf_drain%0d got %0b/%h exp 1/%h", k, tx_valid, tx_data, 8'(k)); end
      tick();
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b exp 0", tx_valid); end
    tx_overflow_clr = 1;
    tick();
    tx_overflow_clr = 0;
    #1;
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", tx_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_d[4];
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h77};
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(4'(i), 8'h10 + 8'(i));
    tx_ready = 1;
    push_byte(4'd9, 8'h77);
    #1;
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got %0b exp 0", tx_overflow); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_d[k])
        begin errors++; $display("FAIL full_pp_seq%0d got %0b/%h exp 1/%h", k, tx_valid, tx_data, exp_d[k]); end
      if (k == 3) begin
        checks++; if (tx_index !== 4'd9) begin errors++; $display("FAIL full_pp_idx got %h exp 9", tx_index); end
      end
      tick();
    end
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got %0b exp 0", tx_valid); end
  endtask

  task automatic test_rx_stall();
    do_reset();
    rx_valid = 1; rx_index = 4'd7; rx_data = 8'h3C;
    #1;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_first_rdy got %0b exp 1", rx_ready); end
    tick();
    rx_data = 8'h5A;
    #1;
    checks++; if (io_in[7] !== 8'h3C || rx_pending !== 16'h0080)
      begin errors++; $display("FAIL rx_first got %h/%h exp 3c/0080", io_in[7], rx_pending); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_stall got %0b exp 0", rx_ready); end
    tick();
    io_read_en = 1; io_read_index = 4'd7;
    #1;
    checks++; if (io_in[7] !== 8'h3C) begin errors++; $display("FAIL rx_hold got %h exp 3c", io_in[7]); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_rdy_on_read got %0b exp 1", rx_ready); end
    tick();
    rx_valid = 0;
    io_read_en = 0;
    #1;
    checks++; if (io_in[7] !== 8'h5A || rx_pending !== 16'h0080)
      begin errors++; $display("FAIL rx_second got %h/%h exp 5a/0080", io_in[7], rx_pending); end
    io_read_en = 1;
    tick();
    io_read_en = 0;
    #1;
    checks++; if (rx_pending !== 16'h0000) begin errors++; $display("FAIL rx_read_clr got %h exp 0000", rx_pending); end
  endtask

  task automatic test_clk_en_and_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) push_byte(4'(i), 8'h20 + 8'(i));
    clk_en = 0; io_write_en = 1; io_write_index = 4'd5; io_out[5] = 8'h55;
    rx_valid = 1; rx_index = 4'd2; rx_data = 8'h99; tx_ready = 1; tx_overflow_clr = 1;
    #1;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL gate_rx_rdy got %0b exp 0", rx_ready); end
    tick();
    tick();
    clk_en = 1; system_enabled = 0;
    tick();
    system_enabled = 1; io_write_en = 0; rx_valid = 0; tx_overflow_clr = 0;
    #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h21)
      begin errors++; $display("FAIL gate_fifo got %0b/%h exp 1/21", tx_valid, tx_data); end
    checks++; if (io_in !== '0 || rx_pending !== 16'h0)
      begin errors++; $display("FAIL gate_rx got %h/%h exp 0/0", io_in[2], rx_pending); end
    tick();
    tx_ready = 0;
    #1;
    checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL gate_drain got %h exp 22", tx_data); end
    sync_rst = 1; rx_valid = 1; rx_index = 4'd2; rx_data = 8'h99;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", tx_valid); end
    tick();
    idle();
    #1;
    checks++; if ({tx_valid, tx_index, tx_data} !== 13'h0 || io_in !== '0 || rx_pending !== 16'h0)
      begin errors++; $display("FAIL midrst_after got %b/%h/%h exp 0/0/0", tx_valid, io_in[2], rx_pending); end
  endtask

  task automatic test_random();
    logic [11:0] head;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      sync_rst        = ($urandom_range(0, 99) < 2);
      clk_en          = ($urandom_range(0, 9) != 0);
      system_enabled  = ($urandom_range(0, 9) != 0);
      io_out          = {$urandom, $urandom, $urandom, $urandom};
      io_write_en     = ($urandom_range(0, 9) < 4);
      io_write_index  = 4'($urandom);
      tx_ready        = $urandom_range(0, 1);
      tx_overflow_clr = ($urandom_range(0, 9) == 0);
      rx_valid        = $urandom_range(0, 1);
      rx_index        = 4'($urandom_range(0, 3));
      rx_data         = 8'($urandom);
      io_read_en      = ($urandom_range(0, 9) < 3);
      io_read_index   = 4'($urandom_range(0, 3));
      #1;
      head = (mq.size() > 0) ? mq[0] : 12'h0;
      checks++; if (tx_valid !== (!sync_rst && mq.size() > 0))
        begin errors++; $display("FAIL rnd_tx_valid c%0d got %0b exp %0b", c, tx_valid, !sync_rst && mq.size() > 0); end
      if (!sync_rst) begin
        checks++; if ({tx_index, tx_data} !== head)
          begin errors++; $display("FAIL rnd_tx_head c%0d got %h exp %h", c, {tx_index, tx_data}, head); end
      end
      checks++; if (rx_ready !== m_rx_ready())
        begin errors++; $display("FAIL rnd_rx_ready c%0d got %0b exp %0b", c, rx_ready, m_rx_ready()); end
      checks++; if (tx_overflow !== m_ovf)
        begin errors++; $display("FAIL rnd_ovf c%0d got %0b exp %0b", c, tx_overflow, m_ovf); end
      checks++; if (rx_pending !== m_pend)
        begin errors++; $display("FAIL rnd_pend c%0d got %h exp %h", c, rx_pending, m_pend); end
      checks++; if (io_in !== m_io)
        begin errors++; $display("FAIL rnd_io_in c%0d got %h exp %h", c, io_in, m_io); end
      tick();
    end
  endtask

  initial begin
    idle();
    mq.delete(); m_io = '0; m_pend = '0; m_ovf = 1'b0;
    test_reset();
    test_single_write();
    test_overflow();
    test_full_push_pop();
    test_rx_stall();
    test_clk_en_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
